// File: rtl/vram_arbiter_if.sv
// Signal bundle between the video fetch path, the CPU bus and the single-port VRAM macro.
// The arbiter side uses the slave modport; requesters and the RAM model use the master modport.
interface vram_arbiter_if #(
    parameter int RAM_ADDR_WIDTH = 13,
    parameter int XLEN           = 8
);
    logic                      vid_req;
    logic [RAM_ADDR_WIDTH-1:0] vid_addr;
    logic                      vid_ack;
    logic                      vid_rvalid;
    logic [XLEN-1:0]           vid_rdata;

    logic                      cpu_req;
    logic                      cpu_we;
    logic [RAM_ADDR_WIDTH-1:0] cpu_addr;
    logic [XLEN-1:0]           cpu_wdata;
    logic                      cpu_ack;
    logic                      cpu_rvalid;
    logic [XLEN-1:0]           cpu_rdata;

    logic                      ram_en;
    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [XLEN-1:0]           ram_wdata;
    logic [XLEN-1:0]           ram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_ack, vid_rvalid, vid_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_ack, vid_rvalid, vid_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Per-cycle VRAM arbiter: video has fixed priority, the CPU is guaranteed a slot after
// CPU_MAX_WAIT consecutive refusals. Read data is steered back one cycle after the grant.
module vram_arbiter #(
    parameter int RAM_SIZE       = 8192,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int XLEN           = 8,
    parameter int CPU_MAX_WAIT   = 4
) (
    input  logic           clk,
    input  logic           rst,
    vram_arbiter_if.slave  bus
);
    localparam int                WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU
    } owner_t;

    owner_t                    rd_owner;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [XLEN-1:0]           vid_hold;
    logic [XLEN-1:0]           cpu_hold;

    logic                      cpu_force;
    logic                      vid_win;
    logic                      cpu_win;
    logic [RAM_ADDR_WIDTH-1:0] addr_mux;
    logic [XLEN-1:0]           wdata_mux;

    // Grants are qualified by rst so nothing reaches the RAM while reset is asserted.
    always_comb begin
        cpu_force = bus.cpu_req && (wait_cnt == WAIT_MAX);
        vid_win   = rst && bus.vid_req && !cpu_force;
        cpu_win   = rst && bus.cpu_req && (cpu_force || !bus.vid_req);

        addr_mux  = '0;
        wdata_mux = '0;
        if (vid_win) begin
            addr_mux = bus.vid_addr;
        end else if (cpu_win) begin
            addr_mux = bus.cpu_addr;
            if (bus.cpu_we) begin
                wdata_mux = bus.cpu_wdata;
            end
        end
    end

    assign bus.vid_ack    = vid_win;
    assign bus.cpu_ack    = cpu_win;
    assign bus.ram_en     = vid_win | cpu_win;
    assign bus.ram_we     = cpu_win & bus.cpu_we;
    assign bus.ram_addr   = addr_mux;
    assign bus.ram_wdata  = wdata_mux;

    assign bus.vid_rvalid = (rd_owner == OWN_VID);
    assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
    assign bus.vid_rdata  = (rd_owner == OWN_VID) ? bus.ram_rdata : vid_hold;
    assign bus.cpu_rdata  = (rd_owner == OWN_CPU) ? bus.ram_rdata : cpu_hold;

    // Grant edge -> return cycle: tag the owner of this cycle's read for next cycle's data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner <= OWN_NONE;
            wait_cnt <= '0;
            vid_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (vid_win) begin
                rd_owner <= OWN_VID;
            end else if (cpu_win && !bus.cpu_we) begin
                rd_owner <= OWN_CPU;
            end else begin
                rd_owner <= OWN_NONE;
            end

            // Saturation is belt-and-braces: at WAIT_MAX the CPU is always granted.
            if (!bus.cpu_req || cpu_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (rd_owner == OWN_VID) begin
                vid_hold <= bus.ram_rdata;
            end
            if (rd_owner == OWN_CPU) begin
                cpu_hold <= bus.ram_rdata;
            end
        end
    end
endmodule
